// File: rtl/jx2_mem_tile_arbiter_if.sv
// Tile-port bundle joining the I-side fetcher, the D-side cache and the
// shared memory port to jx2_mem_tile_arbiter.
interface jx2_mem_tile_arbiter_if;
    logic [47:0]  ifAddr;
    logic [4:0]   ifOpm;
    logic [127:0] ifData;
    logic [1:0]   ifOK;
    logic [47:0]  dfAddr;
    logic [4:0]   dfOpm;
    logic [127:0] dfDataIn;
    logic [127:0] dfData;
    logic [1:0]   dfOK;
    logic [47:0]  memAddr;
    logic [4:0]   memOpm;
    logic [127:0] memDataOut;
    logic [127:0] memData;
    logic [1:0]   memOK;

    modport master (
        output ifAddr, ifOpm, dfAddr, dfOpm, dfDataIn, memData, memOK,
        input  ifData, ifOK, dfData, dfOK, memAddr, memOpm, memDataOut
    );

    modport slave (
        input  ifAddr, ifOpm, dfAddr, dfOpm, dfDataIn, memData, memOK,
        output ifData, ifOK, dfData, dfOK, memAddr, memOpm, memDataOut
    );
endinterface

// File: rtl/jx2_mem_tile_arbiter.sv
// Shares the single memory tile port between the I-side and D-side requesters,
// with round-robin tie breaking and a bus-timeout fault.
module jx2_mem_tile_arbiter #(
    parameter int TIMEOUT = 255
) (
    input logic                   clock,
    input logic                   reset,
    jx2_mem_tile_arbiter_if.slave bus
);

    localparam logic [1:0] OK_READY  = 2'b00;
    localparam logic [1:0] OK_OK     = 2'b01;
    localparam logic [1:0] OK_HOLD   = 2'b10;
    localparam logic [1:0] OK_FAULT  = 2'b11;
    localparam logic [4:0] OPM_READY = 5'h00;
    localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BUSY_I = 3'd1,
        S_BUSY_D = 3'd2,
        S_DONE_I = 3'd3,
        S_DONE_D = 3'd4,
        S_DRAIN  = 3'd5
    } state_e;

    state_e       state_q,     state_d;
    logic         last_d_q,    last_d_d;
    logic [7:0]   cnt_q,       cnt_d;
    logic [4:0]   req_opm_q,   req_opm_d;
    logic [1:0]   rsp_ok_q,    rsp_ok_d;
    logic [47:0]  mem_addr_q,  mem_addr_d;
    logic [4:0]   mem_opm_q,   mem_opm_d;
    logic [127:0] mem_wdata_q, mem_wdata_d;
    logic [127:0] if_data_q,   if_data_d;
    logic [1:0]   if_ok_q,     if_ok_d;
    logic [127:0] df_data_q,   df_data_d;
    logic [1:0]   df_ok_q,     df_ok_d;

    logic i_req;
    logic d_req;
    logic mem_done;

    assign i_req    = (bus.ifOpm != OPM_READY);
    assign d_req    = (bus.dfOpm != OPM_READY);
    assign mem_done = (bus.memOK == OK_OK) || (bus.memOK == OK_FAULT);

    // Next-state and next-output logic; every output is a function of the current state.
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        req_opm_d   = req_opm_q;
        rsp_ok_d    = rsp_ok_q;
        mem_addr_d  = mem_addr_q;
        mem_opm_d   = OPM_READY;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        df_data_d   = df_data_q;
        if_ok_d     = i_req ? OK_HOLD : OK_READY;
        df_ok_d     = d_req ? OK_HOLD : OK_READY;

        case (state_q)
            S_IDLE: begin
                // A tie goes to D unless D was the side served last.
                if (d_req && (!i_req || !last_d_q)) begin
                    state_d     = S_BUSY_D;
                    mem_addr_d  = bus.dfAddr;
                    mem_wdata_d = bus.dfDataIn;
                    req_opm_d   = bus.dfOpm;
                    cnt_d       = 8'd0;
                end else if (i_req) begin
                    state_d    = S_BUSY_I;
                    mem_addr_d = bus.ifAddr;
                    req_opm_d  = bus.ifOpm;
                    cnt_d      = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                mem_opm_d = req_opm_q;
                cnt_d     = cnt_q + 8'd1;
                if (state_q == S_BUSY_I) begin
                    if_ok_d = OK_HOLD;
                end else begin
                    df_ok_d = OK_HOLD;
                end
                if (mem_done || (cnt_q == CNT_LAST)) begin
                    rsp_ok_d = mem_done ? bus.memOK : OK_FAULT;
                    last_d_d = (state_q == S_BUSY_D);
                    if (state_q == S_BUSY_I) begin
                        state_d   = S_DONE_I;
                        if_data_d = bus.memData;
                    end else begin
                        state_d   = S_DONE_D;
                        df_data_d = bus.memData;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DONE_I: begin
                if (i_req) begin
                    if_ok_d = rsp_ok_q;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE_D: begin
                if (d_req) begin
                    df_ok_d = rsp_ok_q;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Memory may keep its last status up for a while after opm drops.
                if (bus.memOK == OK_READY) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            last_d_q    <= 1'b0;
            cnt_q       <= 8'd0;
            req_opm_q   <= OPM_READY;
            rsp_ok_q    <= OK_READY;
            mem_addr_q  <= 48'd0;
            mem_opm_q   <= OPM_READY;
            mem_wdata_q <= 128'd0;
            if_data_q   <= 128'd0;
            if_ok_q     <= OK_READY;
            df_data_q   <= 128'd0;
            df_ok_q     <= OK_READY;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            req_opm_q   <= req_opm_d;
            rsp_ok_q    <= rsp_ok_d;
            mem_addr_q  <= mem_addr_d;
            mem_opm_q   <= mem_opm_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            if_ok_q     <= if_ok_d;
            df_data_q   <= df_data_d;
            df_ok_q     <= df_ok_d;
        end
    end

    assign bus.memAddr    = mem_addr_q;
    assign bus.memOpm     = mem_opm_q;
    assign bus.memDataOut = mem_wdata_q;
    assign bus.ifData     = if_data_q;
    assign bus.ifOK       = if_ok_q;
    assign bus.dfData     = df_data_q;
    assign bus.dfOK       = df_ok_q;

endmodule
